fetch_unit: RTL and testbench

//  Instruction fetch stage; sits directly upstream of ibus and drives its rd_en/addr.
//  - Owns the PC and issues sequential word fetches.
//  - ROM behind ibus returns data one cycle after issue (registered read).
//  - Buffers responses (output register plus a 1-entry skid buffer) so a decode stall loses nothing.
//  - Handles branch/trap redirects, instruction access faults and misaligned targets.

---
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues sequential word fetches to ibus,
// buffers responses (output register + 1-entry skid) and handles redirects,
// access faults and misaligned targets.
// Optional feature macro: FETCH_PERF_CNT_EN enables the issue/stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000  // ROM base, word aligned
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ibus_rd_en,
  output logic [31:0] ibus_addr,
  input  logic [31:0] ibus_rd_data,
  input  logic        ibus_fault,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  input  logic        trap_en,
  input  logic [31:0] trap_target,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_acc_fault,
  output logic        inst_misaligned,
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_stall_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {ST_RUN, ST_MISAL, ST_HALT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg;
  logic        resp_valid_reg, resp_fault_reg;
  logic [31:0] resp_pc_reg;
  logic        skid_valid_reg, skid_fault_reg;
  logic [31:0] skid_pc_reg, skid_inst_reg;
  logic        inst_valid_reg, inst_acc_fault_reg, inst_misaligned_reg;
  logic [31:0] inst_reg, inst_pc_reg;

  logic        redirect;
  logic [31:0] target;
  logic        issue;
  logic        out_free;

  assign redirect = trap_en | branch_en;
  assign target   = trap_en ? trap_target : branch_target;
  // Hold off fetching whenever the response could not be absorbed next cycle.
  assign issue    = (state_reg == ST_RUN) & ~rst & ~redirect & ~skid_valid_reg
                    & ~(stall & inst_valid_reg & resp_valid_reg);
  assign out_free = ~inst_valid_reg | ~stall;

  assign ibus_rd_en      = issue;
  assign ibus_addr       = fetch_pc_reg;
  assign inst_valid      = inst_valid_reg;
  assign inst            = inst_reg;
  assign inst_pc         = inst_pc_reg;
  assign inst_acc_fault  = inst_acc_fault_reg;
  assign inst_misaligned = inst_misaligned_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_RUN;
    else     state_reg <= state_next;
  end

  // Next-state: redirects win; faults and misaligned reports park the unit in HALT.
  always_comb begin
    state_next = state_reg;
    if (redirect) begin
      state_next = (target[1:0] != 2'b00) ? ST_MISAL : ST_RUN;
    end else if (issue && ibus_fault) begin
      state_next = ST_HALT;
    end else if (state_reg == ST_MISAL && out_free && !skid_valid_reg && !resp_valid_reg) begin
      state_next = ST_HALT;
    end
  end

  // PC, response tracking, skid buffer and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg        <= RESET_ADDR;
      resp_valid_reg      <= 1'b0;
      resp_fault_reg      <= 1'b0;
      resp_pc_reg         <= 32'h0;
      skid_valid_reg      <= 1'b0;
      skid_fault_reg      <= 1'b0;
      skid_pc_reg         <= 32'h0;
      skid_inst_reg       <= 32'h0;
      inst_valid_reg      <= 1'b0;
      inst_reg            <= 32'h0;
      inst_pc_reg         <= 32'h0;
      inst_acc_fault_reg  <= 1'b0;
      inst_misaligned_reg <= 1'b0;
    end else if (redirect) begin
      fetch_pc_reg   <= target;
      resp_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      inst_valid_reg <= 1'b0;
    end else begin
      if (issue) begin
        resp_valid_reg <= 1'b1;
        resp_pc_reg    <= fetch_pc_reg;
        resp_fault_reg <= ibus_fault;
        fetch_pc_reg   <= fetch_pc_reg + 32'd4;
      end else begin
        resp_valid_reg <= 1'b0;
      end

      if (out_free) begin
        if (skid_valid_reg) begin
          inst_valid_reg      <= 1'b1;
          inst_reg            <= skid_inst_reg;
          inst_pc_reg         <= skid_pc_reg;
          inst_acc_fault_reg  <= skid_fault_reg;
          inst_misaligned_reg <= 1'b0;
          skid_valid_reg      <= 1'b0;
        end else if (resp_valid_reg) begin
          inst_valid_reg      <= 1'b1;
          inst_reg            <= resp_fault_reg ? NOP : ibus_rd_data;
          inst_pc_reg         <= resp_pc_reg;
          inst_acc_fault_reg  <= resp_fault_reg;
          inst_misaligned_reg <= 1'b0;
        end else if (state_reg == ST_MISAL) begin
          inst_valid_reg      <= 1'b1;
          inst_reg            <= NOP;
          inst_pc_reg         <= fetch_pc_reg;
          inst_acc_fault_reg  <= 1'b0;
          inst_misaligned_reg <= 1'b1;
        end else begin
          inst_valid_reg <= 1'b0;
        end
      end else if (resp_valid_reg) begin
        // Read data is only present this cycle, so park it in the skid entry.
        skid_valid_reg <= 1'b1;
        skid_pc_reg    <= resp_pc_reg;
        skid_fault_reg <= resp_fault_reg;
        skid_inst_reg  <= resp_fault_reg ? NOP : ibus_rd_data;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_issue_cnt_reg, perf_stall_cnt_reg;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_cnt_reg <= 32'h0;
      perf_stall_cnt_reg <= 32'h0;
    end else begin
      if (issue)                   perf_issue_cnt_reg <= perf_issue_cnt_reg + 32'd1;
      if (inst_valid_reg && stall) perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
    end
  end

  assign perf_issue_cnt = perf_issue_cnt_reg;
  assign perf_stall_cnt = perf_stall_cnt_reg;
`else
  assign perf_issue_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cycle-indexed stimulus, a 4kB
// ROM model (word i = i, fault at/above 0x1000) and a scoreboard monitor that
// checks every instruction accepted downstream (inst_valid & ~stall).
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_PERF_CNT_EN
  localparam logic [31:0] EXP_ISSUE = 32'd10;
  localparam logic [31:0] EXP_STALL = 32'd3;
`else
  localparam logic [31:0] EXP_ISSUE = 32'd0;
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus_rd_en;
  logic [31:0] ibus_addr;
  logic [31:0] ibus_rd_data;
  logic        ibus_fault;
  logic        stall;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        trap_en;
  logic [31:0] trap_target;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_acc_fault;
  logic        inst_misaligned;
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        fault;
    logic        misal;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  fetch_unit #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .ibus_rd_en(ibus_rd_en), .ibus_addr(ibus_addr),
    .ibus_rd_data(ibus_rd_data), .ibus_fault(ibus_fault),
    .stall(stall),
    .branch_en(branch_en), .branch_target(branch_target),
    .trap_en(trap_en), .trap_target(trap_target),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_acc_fault(inst_acc_fault), .inst_misaligned(inst_misaligned),
    .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  // ROM model: 4kB, registered read, word i holds i.
  logic [31:0] rom_q = 32'h0;
  always @(posedge clk)
    if (ibus_rd_en)
      rom_q <= (ibus_addr < 32'h1000) ? {2'b00, ibus_addr[31:2]} : 32'hDEAD_BEEF;
  assign ibus_rd_data = rom_q;
  assign ibus_fault   = (ibus_addr >= 32'h1000);

  task automatic push(input logic [31:0] pc, input logic [31:0] ins,
                      input logic fault, input logic misal);
    exp_t e;
    e.pc = pc; e.ins = ins; e.fault = fault; e.misal = misal;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted instruction is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && inst_valid && !stall && !branch_en && !trap_en) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL accept_unexpected: got pc=%h inst=%h expected no instruction", inst_pc, inst);
      end else begin
        mon_e = exp_q.pop_front();
        if (inst_pc !== mon_e.pc || inst !== mon_e.ins ||
            inst_acc_fault !== mon_e.fault || inst_misaligned !== mon_e.misal) begin
          fails++;
          $display("FAIL accept: got pc=%h inst=%h af=%b mis=%b expected pc=%h inst=%h af=%b mis=%b",
                   inst_pc, inst, inst_acc_fault, inst_misaligned,
                   mon_e.pc, mon_e.ins, mon_e.fault, mon_e.misal);
        end else begin
          $display("[TB] accept pc=%h inst=%h af=%b mis=%b", inst_pc, inst,
                   inst_acc_fault, inst_misaligned);
        end
      end
    end
  end

  task automatic idle_inputs();
    stall = 1'b0; branch_en = 1'b0; trap_en = 1'b0;
    branch_target = 32'h0; trap_target = 32'h0;
  endtask

  // Phase 1 schedule: stall/skid, branch under stall, trap vs branch, fault, misaligned.
  task automatic drive1(input int k);
    idle_inputs();
    case (k)
      6, 7, 8, 16: stall = 1'b1;
      17: begin stall = 1'b1; branch_en = 1'b1; branch_target = 32'h100; end
      24: begin trap_en = 1'b1; trap_target = 32'h200; branch_en = 1'b1; branch_target = 32'h100; end
      30: begin branch_en = 1'b1; branch_target = 32'hFF8; end
      40: begin branch_en = 1'b1; branch_target = 32'h102; end
      45: begin trap_en = 1'b1; trap_target = 32'h0; end
      default: ;
    endcase
  endtask

  task automatic check1(input int k);
    case (k)
      0:  begin chk("c0_rd_en", {31'h0, ibus_rd_en}, 32'd1); chk("c0_addr", ibus_addr, 32'h0); end
      1:  begin chk("c1_valid", {31'h0, inst_valid}, 32'd0); chk("c1_addr", ibus_addr, 32'h4); end
      2:  begin chk("c2_valid", {31'h0, inst_valid}, 32'd1); chk("c2_pc", inst_pc, 32'h0); chk("c2_inst", inst, 32'h0); end
      3:  chk("c3_inst", inst, 32'h1);
      4:  chk("c4_pc", inst_pc, 32'h8);
      6:  chk("stall_rd_en_low_start", {31'h0, ibus_rd_en}, 32'd0);
      9:  chk("skid_drain_rd_en_low", {31'h0, ibus_rd_en}, 32'd0);
      10: begin chk("resume_rd_en", {31'h0, ibus_rd_en}, 32'd1); chk("resume_addr", ibus_addr, 32'd24); end
      17: chk("redirect_cycle_rd_en", {31'h0, ibus_rd_en}, 32'd0);
      18: begin chk("post_branch_valid", {31'h0, inst_valid}, 32'd0); chk("branch_addr", ibus_addr, 32'h100); end
      19: chk("branch_valid_r2", {31'h0, inst_valid}, 32'd0);
      20: begin chk("branch_valid_r3", {31'h0, inst_valid}, 32'd1); chk("branch_pc", inst_pc, 32'h100); end
      25: begin chk("trap_prio_rd_en", {31'h0, ibus_rd_en}, 32'd1); chk("trap_prio_addr", ibus_addr, 32'h200); end
      34: chk("fault_halt_rd_en_a", {31'h0, ibus_rd_en}, 32'd0);
      35: chk("fault_flag", {31'h0, inst_acc_fault}, 32'd1);
      39: chk("fault_halt_rd_en_b", {31'h0, ibus_rd_en}, 32'd0);
      41: chk("misal_rd_en", {31'h0, ibus_rd_en}, 32'd0);
      42: chk("misal_flag", {31'h0, inst_misaligned}, 32'd1);
      44: chk("misal_halt_rd_en", {31'h0, ibus_rd_en}, 32'd0);
      46: begin chk("restart_rd_en", {31'h0, ibus_rd_en}, 32'd1); chk("restart_addr", ibus_addr, 32'h0); end
      default: ;
    endcase
  endtask

  // Phase 2 schedule: 10 issues and 3 stalled-valid cycles, then park in HALT.
  task automatic drive2(input int k);
    idle_inputs();
    case (k)
      6, 7, 8: stall = 1'b1;
      14: begin branch_en = 1'b1; branch_target = 32'h102; end
      default: ;
    endcase
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    chk("rst_valid", {31'h0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_flags", {30'h0, inst_acc_fault, inst_misaligned}, 32'd0);
    chk("rst_rd_en", {31'h0, ibus_rd_en}, 32'd0);
    chk("rst_addr", ibus_addr, 32'h0);
    chk("rst_perf_issue", perf_issue_cnt, 32'h0);
    chk("rst_perf_stall", perf_stall_cnt, 32'h0);

    // Phase 1 accepted stream.
    for (int i = 0; i < 10; i++) push(32'(i * 4), 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)  push(32'h100 + 32'(i * 4), 32'h40 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)  push(32'h200 + 32'(i * 4), 32'h80 + 32'(i), 1'b0, 1'b0);
    push(32'hFF8, 32'h3FE, 1'b0, 1'b0);
    push(32'hFFC, 32'h3FF, 1'b0, 1'b0);
    push(32'h1000, NOP, 1'b1, 1'b0);
    push(32'h102, NOP, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)  push(32'(i * 4), 32'(i), 1'b0, 1'b0);

    rst = 1'b0;
    for (int k = 0; k < 52; k++) begin
      drive1(k);
      @(negedge clk);
      check1(k);
      tick();
    end

    // Reset mid-stream discards everything in flight.
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_forces_rd_en_low", {31'h0, ibus_rd_en}, 32'd0);
    tick();
    chk("midrst_valid", {31'h0, inst_valid}, 32'd0);
    chk("midrst_addr", ibus_addr, 32'h0);
    tick();

    // Phase 2 accepted stream.
    for (int i = 0; i < 8; i++) push(32'(i * 4), 32'(i), 1'b0, 1'b0);
    push(32'h102, NOP, 1'b0, 1'b1);

    rst = 1'b0;
    for (int k = 0; k < 21; k++) begin
      drive2(k);
      @(negedge clk);
      if (k == 15) chk("p2_misal_rd_en", {31'h0, ibus_rd_en}, 32'd0);
      if (k == 20) begin
        chk("perf_issue", perf_issue_cnt, EXP_ISSUE);
        chk("perf_stall", perf_stall_cnt, EXP_STALL);
      end
      tick();
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
